serial_rx_402: RTL and testbench
================================

// Module: serial_rx_402
// PURPOSE
//  Serial frame receiver: the receiving end of the Lab402 serial link. Samples the
//  PMOD RXD line and recovers 8-bit words (idle-high, start 0, 8 data LSB-first,
//  [parity], stop 1). Sits between the PMOD input pin and the 7-seg display path.
//  Delivers each word with a one-cycle valid strobe plus error flags.
// PARAMETERS
//  F_CLK    50_000_000  system clock frequency, Hz (Tclk = 20 ns)
//  VEL      115_200     bit rate, bit/s
//  NB       F_CLK/VEL   clocks per bit (derived localparam; must be >= 8)
// PORTS
//  clk        in   1  system clock, rising edge
//  rst_n      in   1  synchronous reset, active low
//  RXD        in   1  serial line, asynchronous to clk, idle = 1
//  dat        out  8  last received word
//  ok_dat     out  1  one-cycle strobe: dat updated, frame good
//  err_frm    out  1  sticky: stop bit sampled as 0
//  err_par    out  1  sticky: parity mismatch (0 when RX_PARITY_EN undefined)
//  busy       out  1  1 from start-bit detect to end of stop-bit sample
//  clr_err    in   1  synchronous clear of err_frm/err_par, one cycle
// BEHAVIOUR
//  - Clock/reset: single domain clk; rst_n sampled on rising edge only, active low.
//  - Reset (rst_n=0): dat=8'h00, ok_dat=0, err_frm=0, err_par=0, busy=0, state=IDLE,
//    counters=0, synchronizer flops=1. Reset mid-frame aborts the frame with no strobe.
//  - Input sync: RXD passes through 2 flops before use. Fall detect on the synced
//    value (prev=1, now=0).
//  - Bit timer cb counts 0..NB-1. Sample point is cb == NB/2 - 1 (mid-bit).
//  - FSM:
//    IDLE  : busy=0; on fall -> START, cb=0.
//    START : at sample point, line=0 -> DATA (bit cnt=0); line=1 -> IDLE
//            (glitch, no error).
//    DATA  : sample 8 bits at successive mid-bits into shift reg, LSB first;
//            after bit 7 -> PAR if RX_PARITY_EN defined, else STOP.
//    PAR   : sample parity bit; mismatch -> err_par set at STOP sample.
//    STOP  : at sample point, line=1 and no parity error -> dat<=shift,
//            ok_dat=1 for exactly one cycle. line=0 -> err_frm=1, dat unchanged,
//            no strobe. Either way -> IDLE on the same edge.
//  - Returning to IDLE at mid-stop lets a back-to-back start edge be caught
//    (0 idle bits between frames supported).
//  - Latency: ok_dat asserts 2 (sync) + (9.5 or 10.5)*NB clocks after the start-bit
//    falling edge on RXD.
//  - Error flags are sticky until clr_err=1 or reset. clr_err together with a new
//    error on the same cycle: the error wins (flag stays 1).
//  - busy rises the cycle after the fall is detected; falls on the STOP-sample edge.
// CONFIGURATION
//  RX_PARITY_EN defined:
//    - frame has an even-parity bit after bit 7 (XOR of data ^ parity must be 0);
//    - err_par is active;
//    - a word with bad parity is not delivered (no ok_dat, dat held).
//  RX_PARITY_EN undefined:
//    - 10-bit frame; err_par tied 0; PAR state not built.
// TESTING
//  1 reset: rst_n=0 for 5 clk with RXD=1 -> dat=00, ok_dat=0, err flags 0, busy=0.
//  2 send 8'hA4 at VEL -> single ok_dat pulse, dat=A4, err_frm=0.
//  3 frames 8'h55, 8'hFF, 8'h00 back-to-back, no idle gap -> three strobes, in
//    order, values exact.
//  4 stop bit forced 0 on 8'h3C -> no strobe, err_frm=1, dat keeps previous;
//    then clr_err -> err_frm=0.
//  5 RXD low pulse of NB/4 clocks -> returns to IDLE, no strobe, no error;
//    rst_n=0 mid-frame -> clean abort, next frame 8'h81 received correctly.
//  6 (RX_PARITY_EN) 8'h07 with wrong parity -> err_par=1, no strobe; correct
//    parity -> dat=07.

Source files
------------

// File: rtl/serial_rx_402.sv
`default_nettype none
// ============================================================================
//  Module      : serial_rx_402
//  Description : Serial frame receiver for the Lab402 link. Recovers 8-bit
//                words from an idle-high asynchronous line (start 0, 8 data
//                bits LSB first, optional even parity, stop 1) and presents
//                each good word with a one-cycle valid strobe.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    F_CLK    system clock frequency in Hz
//    VEL      bit rate in bit/s (F_CLK/VEL clocks per bit, must be >= 8)
//  Ports
//    clk      in   system clock, rising edge
//    rst_n    in   synchronous reset, active low
//    RXD      in   serial line, asynchronous to clk, idle high
//    clr_err  in   one-cycle synchronous clear of the sticky error flags
//    dat      out  last word delivered
//    ok_dat   out  one-cycle strobe, dat just updated with a good word
//    err_frm  out  sticky, a stop bit was sampled low
//    err_par  out  sticky, parity mismatch (tied low without parity)
//    busy     out  high while a frame is being received
//  Build option
//    RX_PARITY_EN  when defined, frames carry an even-parity bit after bit 7
//                  and words with bad parity are dropped and flagged.
// ============================================================================
module serial_rx_402 #(
  parameter int F_CLK = 50_000_000,
  parameter int VEL   = 115_200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       RXD,
  input  logic       clr_err,
  output logic [7:0] dat,
  output logic       ok_dat,
  output logic       err_frm,
  output logic       err_par,
  output logic       busy
);

  localparam int NB  = F_CLK / VEL;
  localparam int CBW = $clog2(NB);

  // The bit timer runs continuously from the start edge, so every bit is
  // sampled at the same phase: one half-bit after its nominal start.
  localparam logic [CBW-1:0] SAMPLE_PT = CBW'(NB / 2 - 1);
  localparam logic [CBW-1:0] LAST_CB   = CBW'(NB - 1);

`ifdef RX_PARITY_EN
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_PAR   = 3'd3,
    S_STOP  = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd4
  } state_t;
`endif

  state_t           state, state_nxt;
  logic             rxd_meta, rxd_sync, rxd_prev;
  logic [CBW-1:0]   cb, cb_nxt;
  logic [2:0]       bit_cnt, bit_cnt_nxt;
  logic [7:0]       shift, shift_nxt;
  logic [7:0]       dat_nxt;
  logic             ok_nxt;
  logic             frm_set;
  logic             fall;
  logic             sample;
`ifdef RX_PARITY_EN
  logic             par_bad, par_bad_nxt;
  logic             par_set;
`endif

  assign fall   = rxd_prev & ~rxd_sync;
  assign sample = (cb == SAMPLE_PT);
  assign busy   = (state != S_IDLE);

  // --------------------------------------------------------------------------
  // Next-state and datapath logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_nxt   = state;
    cb_nxt      = (state == S_IDLE) ? '0 :
                  ((cb == LAST_CB) ? '0 : cb + CBW'(1));
    bit_cnt_nxt = bit_cnt;
    shift_nxt   = shift;
    dat_nxt     = dat;
    ok_nxt      = 1'b0;
    frm_set     = 1'b0;
`ifdef RX_PARITY_EN
    par_bad_nxt = par_bad;
    par_set     = 1'b0;
`endif

    case (state)
      S_IDLE: begin
        if (fall) begin
          state_nxt = S_START;
          cb_nxt    = '0;
`ifdef RX_PARITY_EN
          par_bad_nxt = 1'b0;
`endif
        end
      end

      S_START: begin
        if (sample) begin
          // A line back high at mid-start was a glitch: drop it silently.
          if (!rxd_sync) begin
            state_nxt   = S_DATA;
            bit_cnt_nxt = 3'd0;
          end else begin
            state_nxt = S_IDLE;
          end
        end
      end

      S_DATA: begin
        if (sample) begin
          shift_nxt   = {rxd_sync, shift[7:1]};
          bit_cnt_nxt = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
`ifdef RX_PARITY_EN
            state_nxt = S_PAR;
`else
            state_nxt = S_STOP;
`endif
          end
        end
      end

`ifdef RX_PARITY_EN
      S_PAR: begin
        if (sample) begin
          // Even parity: data bits XOR parity bit must be zero.
          par_bad_nxt = (^shift) ^ rxd_sync;
          state_nxt   = S_STOP;
        end
      end
`endif

      S_STOP: begin
        if (sample) begin
          // Leaving at mid-stop lets a back-to-back start edge be caught.
          state_nxt = S_IDLE;
`ifdef RX_PARITY_EN
          par_set = par_bad;
          if (!rxd_sync) begin
            frm_set = 1'b1;
          end else if (!par_bad) begin
            dat_nxt = shift;
            ok_nxt  = 1'b1;
          end
`else
          if (!rxd_sync) begin
            frm_set = 1'b1;
          end else begin
            dat_nxt = shift;
            ok_nxt  = 1'b1;
          end
`endif
        end
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      rxd_meta <= 1'b1;
      rxd_sync <= 1'b1;
      rxd_prev <= 1'b1;
      cb       <= '0;
      bit_cnt  <= 3'd0;
      shift    <= 8'h00;
      dat      <= 8'h00;
      ok_dat   <= 1'b0;
      err_frm  <= 1'b0;
    end else begin
      state    <= state_nxt;
      rxd_meta <= RXD;
      rxd_sync <= rxd_meta;
      rxd_prev <= rxd_sync;
      cb       <= cb_nxt;
      bit_cnt  <= bit_cnt_nxt;
      shift    <= shift_nxt;
      dat      <= dat_nxt;
      ok_dat   <= ok_nxt;
      // A new error on the same cycle as clr_err takes precedence.
      err_frm  <= frm_set | (err_frm & ~clr_err);
    end
  end

`ifdef RX_PARITY_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      par_bad <= 1'b0;
      err_par <= 1'b0;
    end else begin
      par_bad <= par_bad_nxt;
      err_par <= par_set | (err_par & ~clr_err);
    end
  end
`else
  assign err_par = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_serial_rx_402.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_rx_402
//  Description : Self-checking bench for serial_rx_402. Frames are built bit
//                by bit from a word, the words expected at the output are
//                kept in a queue and compared against every ok_dat strobe.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_rx_402;

  localparam int F_CLK = 50_000_000;
  localparam int VEL   = 3_125_000;
  localparam int NB    = F_CLK / VEL;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       RXD = 1'b1;
  logic       clr_err = 1'b0;
  logic [7:0] dat;
  logic       ok_dat;
  logic       err_frm;
  logic       err_par;
  logic       busy;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [7:0] exp_q[$];
  logic [7:0] last_good = 8'h00;
  int         exp_strobes = 0;
  int         strobes = 0;
  logic       exp_frm = 1'b0;
  logic       exp_par = 1'b0;
  logic       prev_ok = 1'b0;

  serial_rx_402 #(.F_CLK(F_CLK), .VEL(VEL)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .RXD     (RXD),
    .clr_err (clr_err),
    .dat     (dat),
    .ok_dat  (ok_dat),
    .err_frm (err_frm),
    .err_par (err_par),
    .busy    (busy)
  );

  always #10 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Strobe monitor: every strobe must match the oldest expected word and
  // last exactly one cycle.
  always @(negedge clk) begin
    if (ok_dat === 1'b1) begin
      strobes++;
      chk("strobe_width", {31'd0, prev_ok}, 32'd0);
      if (exp_q.size() > 0) begin
        chk("strobe_dat", {24'd0, dat}, {24'd0, exp_q[0]});
        void'(exp_q.pop_front());
      end else begin
        chk("unexpected_strobe", 32'd1, 32'd0);
      end
    end
    prev_ok = (ok_dat === 1'b1);
  end

  task automatic send_bit(input logic b);
    RXD = b;
    repeat (NB) @(negedge clk);
  endtask

  task automatic idle_bits(input int n);
    RXD = 1'b1;
    repeat (n * NB) @(negedge clk);
  endtask

  // Send one frame and update the model. stop_bit=0 forces a framing error,
  // bad_par flips the parity bit when parity is built in.
  task automatic send_frame(input logic [7:0] d, input logic stop_bit, input logic bad_par);
    logic good;
    good = stop_bit;
`ifdef RX_PARITY_EN
    good = good & ~bad_par;
`endif
    if (good) begin
      exp_q.push_back(d);
      exp_strobes++;
      last_good = d;
    end
    if (!stop_bit) exp_frm = 1'b1;
`ifdef RX_PARITY_EN
    if (bad_par) exp_par = 1'b1;
`endif
    send_bit(1'b0);
    chk("busy_in_frame", {31'd0, busy}, 32'd1);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef RX_PARITY_EN
    send_bit((^d) ^ bad_par);
`endif
    send_bit(stop_bit);
  endtask

  task automatic check_state(input string tag);
    chk({tag, "_strobes"}, strobes, exp_strobes);
    chk({tag, "_dat"}, {24'd0, dat}, {24'd0, last_good});
    chk({tag, "_err_frm"}, {31'd0, err_frm}, {31'd0, exp_frm});
    chk({tag, "_err_par"}, {31'd0, err_par}, {31'd0, exp_par});
  endtask

  task automatic do_reset(input int n);
    RXD   = 1'b1;
    rst_n = 1'b0;
    repeat (n) @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    last_good = 8'h00;
    exp_frm   = 1'b0;
    exp_par   = 1'b0;
  endtask

  initial begin
    logic [7:0] r;

    // 1: reset
    do_reset(5);
    chk("rst_dat", {24'd0, dat}, 32'h0);
    chk("rst_ok", {31'd0, ok_dat}, 32'd0);
    chk("rst_err_frm", {31'd0, err_frm}, 32'd0);
    chk("rst_err_par", {31'd0, err_par}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    idle_bits(1);

    // 2: single word
    send_frame(8'hA4, 1'b1, 1'b0);
    check_state("a4");
    idle_bits(1);

    // 3: back-to-back, no idle gap
    send_frame(8'h55, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b0);
    send_frame(8'h00, 1'b1, 1'b0);
    check_state("b2b");
    chk("b2b_queue_empty", exp_q.size(), 32'd0);
    idle_bits(1);

    // Random words with random idle gaps
    for (int k = 0; k < 10; k++) begin
      r = 8'($urandom);
      send_frame(r, 1'b1, 1'b0);
      idle_bits(int'($urandom_range(0, 2)));
    end
    check_state("rand");

    // 4: framing error keeps dat, then clear
    send_frame(8'h3C, 1'b0, 1'b0);
    idle_bits(2);
    check_state("frm");
    @(negedge clk) clr_err = 1'b1;
    @(negedge clk) clr_err = 1'b0;
    exp_frm = 1'b0;
    chk("clr_err_frm", {31'd0, err_frm}, 32'd0);

    // 5a: short low glitch
    RXD = 1'b0;
    repeat (NB / 4) @(negedge clk);
    idle_bits(2);
    check_state("glitch");
    chk("glitch_busy", {31'd0, busy}, 32'd0);

    // 5b: reset in the middle of a frame
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    do_reset(3);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_dat", {24'd0, dat}, 32'h0);
    idle_bits(1);
    send_frame(8'h81, 1'b1, 1'b0);
    idle_bits(1);
    check_state("after_abort");

`ifdef RX_PARITY_EN
    // 6: parity
    send_frame(8'h07, 1'b1, 1'b1);
    idle_bits(1);
    check_state("par_bad");
    send_frame(8'h07, 1'b1, 1'b0);
    idle_bits(1);
    check_state("par_good");
`endif

    chk("final_queue_empty", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #5ms;
    $display("FAIL timeout: simulation did not finish, observed running expected done");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
